// File: rtl/rtc_clock_core.sv
// rtc_clock_core
//   24-hour timekeeping core with a 12/24-hour BCD display view.
//   A prescaler derives a one-cycle tick_1Hz enable from clk_50MHz. Seconds,
//   minutes and hours (0-23) advance on that enable. Three raw buttons are
//   synchronised, debounced and edge-detected into one-cycle press pulses.
//   A sticky alarm is raised by the tick that reaches HH:MM:00.
//
// Ports
//   clk_50MHz    system clock (sole clock domain)
//   reset        asynchronous, active-low reset
//   run          1 = prescaler and time advance, 0 = hold
//   mode_24h     display format: 0 = 12-hour, 1 = 24-hour
//   btn_hr       raw button, hour + 1 (mod 24)
//   btn_min      raw button, minute + 1 (mod 60, no carry)
//   btn_sec_clr  raw button, clears seconds and prescaler
//   alarm_en     alarm enable; 0 also clears a raised alarm
//   alarm_hr     alarm hour 0-23
//   alarm_min    alarm minute 0-59
//   alarm_ack    clears the alarm
//   tick_1Hz     one-cycle pulse per second
//   am_pm        0 = hours 0-11, 1 = hours 12-23
//   end_of_day   one-cycle pulse after the tick wrapping 23:59:59 -> 00:00:00
//   alarm        sticky alarm flag
//   sec_*/min_*/hr_*  BCD display digits
module rtc_clock_core #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       run,
    input  logic       mode_24h,
    input  logic       btn_hr,
    input  logic       btn_min,
    input  logic       btn_sec_clr,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       alarm_ack,
    output logic       tick_1Hz,
    output logic       am_pm,
    output logic       end_of_day,
    output logic       alarm,
    output logic [3:0] sec_1s,
    output logic [3:0] sec_10s,
    output logic [3:0] min_1s,
    output logic [3:0] min_10s,
    output logic [3:0] hr_1s,
    output logic [3:0] hr_10s
);
    localparam int PRE_W = $clog2(CLK_FREQ_HZ);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ_HZ - 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = hour, 1 = minute, 2 = seconds clear
    // ------------------------------------------------------------------
    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_sec_clr, btn_min, btn_hr};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic            level_d_reg;
            logic            press_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk_50MHz or negedge reset) begin
                if (!reset) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    press_reg   <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;
                    // Rising edge of the accepted level only: a held button
                    // yields a single pulse.
                    press_reg   <= level_reg & ~level_d_reg;
                    // Count consecutive cycles of disagreement; any return to
                    // agreement restarts the count.
                    if (sync2_reg != level_reg) begin
                        if (cnt_reg == DB_MAX) begin
                            level_reg <= sync2_reg;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + DB_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_reg;
    logic             tick_reg;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            pre_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (press[2]) begin
            // Restart the second so the next tick is a full period away.
            pre_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (run) begin
            if (pre_reg == PRE_MAX) begin
                pre_reg  <= '0;
                tick_reg <= 1'b1;
            end else begin
                pre_reg  <= pre_reg + PRE_W'(1);
                tick_reg <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
        end
    end

    assign tick_1Hz = tick_reg;

    // ------------------------------------------------------------------
    // Time counters: tick result first, then button increments on top
    // ------------------------------------------------------------------
    logic [5:0] sec_reg, sec_next;
    logic [5:0] min_reg, min_next;
    logic [4:0] hr_reg, hr_next;
    logic       eod_reg, eod_next;
    logic       alarm_reg, alarm_hit;

    always_comb begin
        sec_next  = sec_reg;
        min_next  = min_reg;
        hr_next   = hr_reg;
        eod_next  = 1'b0;
        alarm_hit = 1'b0;

        if (press[2]) begin
            // A coincident tick is dropped along with the cleared second.
            sec_next = 6'd0;
        end else if (tick_reg) begin
            if (sec_reg == 6'd59) begin
                sec_next = 6'd0;
                if (min_reg == 6'd59) begin
                    min_next = 6'd0;
                    if (hr_reg == 5'd23) begin
                        hr_next  = 5'd0;
                        eod_next = 1'b1;
                    end else begin
                        hr_next = hr_reg + 5'd1;
                    end
                end else begin
                    min_next = min_reg + 6'd1;
                end
            end else begin
                sec_next = sec_reg + 6'd1;
            end
            // Evaluated on the tick result only, so presses never trigger it.
            // Out-of-range alarm settings can never equal a valid counter.
            alarm_hit = alarm_en && (sec_next == 6'd0) &&
                        (hr_next == alarm_hr) && (min_next == alarm_min);
        end

        if (press[0]) begin
            hr_next = (hr_next == 5'd23) ? 5'd0 : hr_next + 5'd1;
        end
        if (press[1]) begin
            min_next = (min_next == 6'd59) ? 6'd0 : min_next + 6'd1;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sec_reg   <= 6'd0;
            min_reg   <= 6'd0;
            hr_reg    <= 5'd0;
            eod_reg   <= 1'b0;
            alarm_reg <= 1'b0;
        end else begin
            sec_reg <= sec_next;
            min_reg <= min_next;
            hr_reg  <= hr_next;
            eod_reg <= eod_next;
            // Set has priority over acknowledge.
            if (alarm_hit) begin
                alarm_reg <= 1'b1;
            end else if (alarm_ack || !alarm_en) begin
                alarm_reg <= 1'b0;
            end
        end
    end

    assign end_of_day = eod_reg;
    assign alarm      = alarm_reg;

    // ------------------------------------------------------------------
    // Display conversion
    // ------------------------------------------------------------------
    logic [4:0] hr_disp;

    always_comb begin
        hr_disp = hr_reg;
        if (!mode_24h) begin
            if (hr_reg == 5'd0) begin
                hr_disp = 5'd12;
            end else if (hr_reg > 5'd12) begin
                hr_disp = hr_reg - 5'd12;
            end
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        tens = (v >= 6'd50) ? 4'd5 :
               (v >= 6'd40) ? 4'd4 :
               (v >= 6'd30) ? 4'd3 :
               (v >= 6'd20) ? 4'd2 :
               (v >= 6'd10) ? 4'd1 : 4'd0;
        return {tens, 4'(v - 6'(tens) * 6'd10)};
    endfunction

    assign {sec_10s, sec_1s} = to_bcd(sec_reg);
    assign {min_10s, min_1s} = to_bcd(min_reg);
    assign {hr_10s, hr_1s}   = to_bcd({1'b0, hr_disp});
    assign am_pm             = (hr_reg >= 5'd12);

endmodule

// File: doc/rtc_clock_core.md
Name: rtc_clock_core

Overview:
Parametrised successor to the single-rate 12-hour BCD clock. Timekeeping runs in one clock domain from a tick enable, with no derived-clock edges. Hours are held internally as 0-23 and shown in either 12-hour or 24-hour format. Adds debounced, edge-detected set buttons, a run/hold control, a seconds-clear input, a one-cycle end-of-day pulse and a sticky alarm. Sits between the board buttons/system clock and the display/home-automation logic.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock cycles per second; minimum 2.
DEBOUNCE_CYCLES, 500_000, consecutive stable cycles required before a button level is accepted; minimum 1.

Ports:
clk_50MHz  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
run  in  1  1 = time advances; 0 = prescaler and time hold.
mode_24h  in  1  display format: 0 = 12-hour, 1 = 24-hour.
btn_hr  in  1  raw asynchronous button: increment hour.
btn_min  in  1  raw asynchronous button: increment minute.
btn_sec_clr  in  1  raw asynchronous button: clear seconds and prescaler.
alarm_en  in  1  alarm enable.
alarm_hr  in  5  alarm hour, 0-23.
alarm_min  in  6  alarm minute, 0-59.
alarm_ack  in  1  clears the alarm output.
tick_1Hz  out  1  one-cycle pulse, once per second.
am_pm  out  1  0 = AM (hour 0-11), 1 = PM (hour 12-23), in both display modes.
end_of_day  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
alarm  out  1  sticky alarm flag.
sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s  out  4 each  BCD display digits.

Behaviour:
- Reset: prescaler 0, time 00:00:00, debouncers and synchronisers 0, tick_1Hz/end_of_day/alarm 0. The display then reads 12:00:00 AM in 12-hour mode and 00:00:00 in 24-hour mode. Reset is honoured mid-operation on any cycle.
- Prescaler: counts 0..CLK_FREQ_HZ-1 while run=1. tick_1Hz is registered and asserts for the one cycle after the count equals CLK_FREQ_HZ-1; the count then wraps to 0. The first tick follows reset release by CLK_FREQ_HZ cycles. With run=0 the prescaler freezes and no ticks are issued.
- Time advance on a tick: seconds increment modulo 60. A carry increments minutes modulo 60, and a further carry increments hours modulo 24.
- Debounce, per button: 2-flop synchroniser, then a counter. The debounced level takes the synchronised value once that value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count. A rising edge of the debounced level gives a one-cycle press pulse. Holding a button gives exactly one pulse (no auto-repeat). Press latency from the raw edge is DEBOUNCE_CYCLES+3 cycles.
- Hour press: hours = (hours+1) mod 24. Never touches minutes or seconds.
- Minute press: minutes = (minutes+1) mod 60. Never carries into hours.
- Press and tick in the same cycle: the tick result, including any carries, is computed first, then the press increment is applied to that result for its own field. No tick is lost.
- sec_clr press: seconds = 0 and prescaler = 0. Any tick in the same cycle is discarded. Minutes and hours are kept.
- Presses are accepted whether or not run is asserted.
- Display conversion (combinational from the registered counters):
  - 24-hour mode: hour digits show 0-23 directly.
  - 12-hour mode: hour 0 shows 12; hours 1-12 show as-is; hours 13-23 show hour-12.
  - Minutes and seconds show directly in BCD.
- end_of_day: registered; asserts for the one cycle after a tick that wraps 23:59:59 to 00:00:00. Wraps caused by button presses do not assert it.
- Alarm: sets in the cycle after a tick that leaves seconds = 0 with hours == alarm_hr, minutes == alarm_min and alarm_en = 1.
  - Out-of-range alarm values never match.
  - Button presses that land on the alarm time do not set it.
  - The alarm stays set until alarm_ack=1 or alarm_en=0.
  - If set and ack occur in the same cycle, set wins.
- All state lives in the clk_50MHz domain; no other clock edges are used.

Test Plan:
1. CLK_FREQ_HZ=10, DEBOUNCE_CYCLES=4, run=1 after reset -> tick_1Hz is a 1-cycle pulse every 10 cycles, first pulse on cycle 10. Seconds read 01, 02, ... After 60 ticks the display reads 00:01:00. With run=0 for 25 cycles, time and prescaler are frozen.
2. Set 23:59:58 using 23 hour presses and 59 minute presses, then wait 2 ticks -> end_of_day pulses for exactly 1 cycle and the time is 00:00:00 with am_pm=0. mode_24h=0 shows hr_10s=1, hr_1s=2; mode_24h=1 shows 0, 0.
3. 12-hour display at hours 0/11/12/13 -> 12 AM / 11 AM / 12 PM / 01 PM. mode_24h=1 shows 00/11/12/13 with am_pm = 0/0/1/1.
4. Debounce:
   - btn_min high for 3 cycles -> no change.
   - High for 10 cycles -> exactly one increment.
   - Minute 59 plus a press -> minute 00, hours unchanged.
   - Press landing in the same cycle as a tick at 00:00:59 -> 00:02:00.
5. Alarm at 00:01 with alarm_en=1 -> alarm=1 on the cycle after the 60th tick; it stays high through later ticks. alarm_ack clears it. Pressing minutes onto 00:01 with seconds 00 does not set it.
6. sec_clr at seconds 37 -> 00, prescaler restarts, next tick 10 cycles later. Reset asserted mid-count -> immediate 00:00:00 and all outputs 0.
